// File: rtl/mini_cpu_pkg.sv
// Shared widths, reset defaults and redirect encodings for the Mini-CPU
// fetch unit and its return stack.
package mini_cpu_pkg;

  localparam int PC_W        = 9;
  localparam int INSTR_W     = 12;
  localparam int STACK_DEPTH = 2;
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam pc_t    RESET_VEC_DEF = 9'h1FF;
  localparam instr_t NOP_WORD_DEF  = 12'h000;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_RET,
    SEL_CALL,
    SEL_GOTO,
    SEL_PCL,
    SEL_SKIP
  } redir_e;

endpackage

// File: rtl/pc_stack.sv
// Two-entry return stack with saturating depth and sticky overflow flag.
// Push and pop arrive already qualified (never both, never while stalled).
module pc_stack
  import mini_cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pc_t  value,
  output pc_t  tos,
  output logic ovf
);

  pc_t               s0;
  pc_t               s1;
  logic [DEPTH_W-1:0] depth;

  assign tos = s0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= '0;
      s1    <= '0;
      depth <= '0;
      ovf   <= 1'b0;
    end else if (push) begin
      s1 <= s0;
      s0 <= value;
      if (depth == DEPTH_W'(STACK_DEPTH)) begin
        ovf <= 1'b1;
      end else begin
        depth <= depth + DEPTH_W'(1);
      end
    end else if (pop) begin
      s0 <= s1;
      if (depth != '0) begin
        depth <= depth - DEPTH_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// PC, execute-stage Instr register and redirect priority for the Mini-CPU.
// Define INSTR_FETCH_PCL_WR_EN to let execute-stage PCL writes redirect.
module instr_fetch
  import mini_cpu_pkg::*;
#(
  parameter pc_t    RESET_VEC = RESET_VEC_DEF,
  parameter instr_t NOP_WORD  = NOP_WORD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  output logic [8:0]   pm_addr,
  input  logic [11:0]  pm_data,
  output logic [11:0]  Instr,
  output logic         instr_valid,
  input  logic         CALL,
  input  logic         GOTO,
  input  logic         RETLW,
  input  logic         skip,
  input  logic         pcl_wr,
  input  logic [7:0]   pcl_data,
  input  logic         stall,
  output logic         stack_ovf
);

  pc_t    pc;
  pc_t    pc_nxt;
  pc_t    pc_inc;
  pc_t    tos;
  redir_e sel;
  logic   take;
  logic   pcl_req;
  logic   ctl;
  logic   flush;

`ifdef INSTR_FETCH_PCL_WR_EN
  assign pcl_req = pcl_wr;
`else
  logic unused_pcl;
  assign pcl_req    = 1'b0;
  assign unused_pcl = pcl_wr;
`endif

  assign pm_addr = pc;
  assign pc_inc  = pc + PC_W'(1);
  assign take    = instr_valid & ~stall;
  assign ctl     = RETLW | CALL | GOTO;

  // Conditions are made mutually exclusive to encode the priority order.
  always_comb begin
    sel = SEL_SEQ;
    unique case (1'b1)
      take & RETLW:                          sel = SEL_RET;
      take & CALL & ~RETLW:                  sel = SEL_CALL;
      take & GOTO & ~CALL & ~RETLW:          sel = SEL_GOTO;
      take & pcl_req & ~ctl:                 sel = SEL_PCL;
      take & skip & ~pcl_req & ~ctl:         sel = SEL_SKIP;
      default:                               sel = SEL_SEQ;
    endcase
  end

  always_comb begin
    pc_nxt = pc_inc;
    unique case (sel)
      SEL_RET:  pc_nxt = tos;
      SEL_CALL: pc_nxt = {1'b0, Instr[7:0]};
      SEL_GOTO: pc_nxt = Instr[PC_W-1:0];
      SEL_PCL:  pc_nxt = {1'b0, pcl_data};
      default:  pc_nxt = pc_inc;
    endcase
  end

  assign flush = (sel != SEL_SEQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VEC;
      Instr       <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      pc <= pc_nxt;
      if (flush) begin
        Instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end else begin
        Instr       <= pm_data;
        instr_valid <= 1'b1;
      end
    end
  end

  // The pushed return address is the word already being fetched (A+1).
  pc_stack u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (sel == SEL_CALL),
    .pop   (sel == SEL_RET),
    .value (pc),
    .tos   (tos),
    .ovf   (stack_ovf)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: ROM program drives the flow, a monitor
// checks every freshly presented valid Instr against a queue of expectations.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [8:0]  pm_addr;
  logic [11:0] pm_data;
  logic [11:0] Instr;
  logic        instr_valid;
  logic        CALL;
  logic        GOTO;
  logic        RETLW;
  logic        skip;
  logic        pcl_wr;
  logic [7:0]  pcl_data;
  logic        stall;
  logic        stack_ovf;

  logic [11:0] rom [512];
  logic [11:0] exp_q [$];
  int          vecs = 0;
  int          errs = 0;
  bit          mon_en = 0;
  logic        held = 1'b0;

  localparam logic [11:0] W030 = 12'h230;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .CALL        (CALL),
    .GOTO        (GOTO),
    .RETLW       (RETLW),
    .skip        (skip),
    .pcl_wr      (pcl_wr),
    .pcl_data    (pcl_data),
    .stall       (stall),
    .stack_ovf   (stack_ovf)
  );

  always #5 clk = ~clk;

  assign pm_data = rom[pm_addr];
  assign GOTO    = (Instr[11:9] == 3'b101);
  assign CALL    = (Instr[11:8] == 4'b1001);
  assign RETLW   = (Instr[11:8] == 4'b1000);
  assign skip    = instr_valid && (Instr == W030);

  function automatic logic [11:0] mk(input logic [8:0] a);
    return {3'b001, a};
  endfunction

  task automatic chk(input string name, input logic [11:0] act,
                     input logic [11:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_instr(input logic [11:0] v);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (instr_valid && Instr == v) return;
    end
    vecs++;
    errs++;
    $display("FAIL wait_instr: Instr %h never seen, got %h", v, Instr);
  endtask

  always @(posedge clk) held <= stall && !rst;

  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (mon_en && instr_valid && !held) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL sb_extra: got %h want none", Instr);
      end else begin
        e = exp_q.pop_front();
        if (Instr !== e) begin
          errs++;
          $display("FAIL sb_instr: got %h want %h", Instr, e);
        end
      end
    end
  end

  initial begin
    clk = 0; rst = 1; stall = 0; pcl_wr = 0; pcl_data = 8'h00;
    for (int i = 0; i < 512; i++) rom[i] = mk(9'(i));
    rom[9'h010] = 12'hAA5;
    rom[9'h0A6] = 12'hA20;
    rom[9'h020] = 12'h940;
    rom[9'h040] = 12'h800;
    rom[9'h021] = 12'hA30;
    rom[9'h033] = 12'hAC0;
    rom[9'h0C1] = 12'hAE0;

    exp_q.push_back(mk(9'h1FF));
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(9'(i)));
    exp_q.push_back(12'hAA5);
    exp_q.push_back(mk(9'h0A5));
    exp_q.push_back(12'hA20);
    exp_q.push_back(12'h940);
    exp_q.push_back(12'h800);
    exp_q.push_back(12'hA30);
    exp_q.push_back(W030);
    exp_q.push_back(mk(9'h032));
    exp_q.push_back(12'hAC0);
    exp_q.push_back(mk(9'h0C0));
    exp_q.push_back(12'hAE0);
    exp_q.push_back(mk(9'h0E0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", {3'b0, pm_addr}, 12'h1FF);
    chk("rst_valid", {11'b0, instr_valid}, 12'h000);
    chk("rst_instr", Instr, 12'h000);
    chk("rst_ovf", {11'b0, stack_ovf}, 12'h000);
    mon_en = 1;
    rst = 0;
`ifndef INSTR_FETCH_PCL_WR_EN
    pcl_wr = 1; pcl_data = 8'h77;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("run_pc", {3'b0, pm_addr}, 12'(i));
      chk("run_valid", {11'b0, instr_valid}, 12'h001);
    end

    wait_instr(12'hAA5);
    @(negedge clk);
    chk("goto_pc", {3'b0, pm_addr}, 12'h0A5);
    chk("goto_valid", {11'b0, instr_valid}, 12'h000);
    chk("goto_nop", Instr, 12'h000);
    pcl_wr = 0;

    wait_instr(12'h800);
    @(negedge clk);
    chk("ret_pc", {3'b0, pm_addr}, 12'h021);
    chk("ret_valid", {11'b0, instr_valid}, 12'h000);

    wait_instr(W030);
    @(negedge clk);
    chk("skip_pc", {3'b0, pm_addr}, 12'h032);
    chk("skip_valid", {11'b0, instr_valid}, 12'h000);

    wait_instr(12'hAE0);
    stall = 1;
    repeat (3) @(negedge clk);
    chk("stall_pc", {3'b0, pm_addr}, 12'h0C2);
    chk("stall_instr", Instr, 12'hAE0);
    chk("stall_valid", {11'b0, instr_valid}, 12'h001);
    stall = 0;
    @(negedge clk);
    chk("unstall_pc", {3'b0, pm_addr}, 12'h0E0);
    chk("unstall_valid", {11'b0, instr_valid}, 12'h000);

    wait_instr(mk(9'h0E0));
    stall = 1;
    @(negedge clk);
    chk("stall2_pc", {3'b0, pm_addr}, 12'h0E1);
    rst = 1;
    rom[9'h001] = 12'h950;
    rom[9'h050] = 12'hB01;
    rom[9'h101] = 12'h960;
    rom[9'h060] = 12'hB02;
    rom[9'h102] = 12'h970;
    rom[9'h070] = 12'h800;
    rom[9'h103] = 12'h800;
    @(negedge clk);
    chk("rst2_pc", {3'b0, pm_addr}, 12'h1FF);
    chk("rst2_valid", {11'b0, instr_valid}, 12'h000);
    chk("rst2_instr", Instr, 12'h000);
    chk("q1_empty", 12'(exp_q.size()), 12'h000);

    exp_q.push_back(mk(9'h1FF));
    exp_q.push_back(mk(9'h000));
    exp_q.push_back(12'h950);
    exp_q.push_back(12'hB01);
    exp_q.push_back(12'h960);
    exp_q.push_back(12'hB02);
    exp_q.push_back(12'h970);
    exp_q.push_back(12'h800);
    exp_q.push_back(12'h800);
    exp_q.push_back(12'h970);
    rst = 0;
    stall = 0;

    wait_instr(12'h970);
    chk("ovf_before", {11'b0, stack_ovf}, 12'h000);
    wait_instr(12'h800);
    chk("ovf_after", {11'b0, stack_ovf}, 12'h001);
    @(negedge clk);
    chk("ret1_pc", {3'b0, pm_addr}, 12'h103);
    wait_instr(12'h800);
    @(negedge clk);
    chk("ret2_pc", {3'b0, pm_addr}, 12'h102);
    wait_instr(12'h970);
    @(negedge clk);
    mon_en = 0;
    chk("q2_empty", 12'(exp_q.size()), 12'h000);
    chk("ovf_sticky", {11'b0, stack_ovf}, 12'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and program-flow unit for the Mini-CPU. It produces the 12-bit `Instr` word that the instruction decoder consumes. It also acts on the decoder's control-flow outputs (`CALL`, `GOTO`, `RETLW`) and on the datapath skip condition. It owns the program counter, the two-level return stack, and the one-stage fetch/execute pipeline with NOP flush.

## Interface
Parameters:
- `RESET_VEC`, default 9'h1FF: PC value loaded on reset.
- `NOP_WORD`, default 12'h000: word injected into `Instr` on flush or reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pm_addr`  out  9  program memory address; always equal to the PC register.
- `pm_data`  in  12  program memory read data; combinational read of `pm_addr`.
- `Instr`  out  12  registered instruction in the execute stage; drives the decoder.
- `instr_valid`  out  1  `Instr` holds a fetched word, not an injected NOP.
- `CALL`, `GOTO`, `RETLW`  in  1 each  decoder outputs for the current `Instr`.
- `skip`  in  1  datapath skip request: FSZ result is zero, or the BTFSS condition is true.
- `pcl_wr`  in  1  execute-stage write to PCL.
- `pcl_data`  in  8  value written to PCL.
- `stall`  in  1  freezes all state (SLEEP, external wait).
- `stack_ovf`  out  1  sticky flag: push attempted with stack already full.

## Operation
- Pipeline: while `Instr` executes the word at address A, `pm_addr` = A+1 is being fetched.
- Normal cycle:
  - PC <= PC+1, modulo 512 (9'h1FF wraps to 9'h000).
  - `Instr` <= `pm_data`.
  - `instr_valid` <= 1.
- Redirect priority, evaluated only when `instr_valid`=1 and `stall`=0: RETLW > CALL > GOTO > PCL write > skip.
  - RETLW: PC <= TOS; pop.
  - CALL: push PC (A+1); PC <= {1'b0, `Instr`[7:0]}.
  - GOTO: PC <= `Instr`[8:0].
  - PCL write (macro enabled only): PC <= {1'b0, `pcl_data`}.
  - skip: PC <= PC+1. The word being fetched is discarded.
- Every redirect and every skip is a flush: `Instr` <= `NOP_WORD` and `instr_valid` <= 0.
- Stack: two entries, S0 (top of stack, TOS) and S1, plus a depth count 0..2.
  - Push: S1 <= S0; S0 <= value; depth saturates at 2. A push with depth=2 discards the old S1 and sets `stack_ovf`.
  - Pop: PC <= S0; S0 <= S1; S1 is unchanged; depth decrements, floor 0.
  - Pop at depth 0 still returns S0 and does not flag.
- `stall`=1 takes priority over everything: PC, `Instr`, `instr_valid`, stack and `stack_ovf` all hold. Control inputs are re-evaluated when `stall` drops.
- Reset values:
  - PC = `RESET_VEC`
  - `Instr` = `NOP_WORD`
  - `instr_valid` = 0
  - S0 = S1 = 0, depth = 0
  - `stack_ovf` = 0
- `rst` overrides `stall` and any in-flight redirect.

## Timing
- Reset: `rst` high at edge t. At t+1, `pm_addr`=`RESET_VEC` and `Instr`=NOP. At t+2, `Instr`=ROM[`RESET_VEC`].
- Sequential instruction: 1 cycle each.
- Taken GOTO, CALL, RETLW, PCL write, or skip: 2 cycles (instruction plus one NOP slot).
- Redirect in execute cycle t: `pm_addr`=target at t+1; `Instr`=ROM[target] at t+2.
- `CALL`/`GOTO`/`RETLW` are combinational from `Instr`. There must be no combinational path from them to `Instr` or `pm_addr` within the same cycle; both outputs are registered.

## Configuration
- `INSTR_FETCH_PCL_WR_EN`:
  - Defined: `pcl_wr` redirects PC as described above and flushes.
  - Undefined: `pcl_wr` and `pcl_data` are ignored; the ports remain present and unused, and no flush occurs.

## Structure
- `mini_cpu_pkg` holds: `PC_W`=9, `INSTR_W`=12, `NOP_WORD` default, `RESET_VEC` default, and the stack depth constant (2).
- Sub-module `pc_stack` contains S0, S1, depth and `stack_ovf`, with push/pop/value/TOS ports. `instr_fetch` contains the PC, the `Instr` register and the redirect priority logic.

## Test plan
- Reset then free-run over a ROM of NOPs: `pm_addr` steps 1FF, 000, 001, …; `instr_valid` goes high on the second cycle after reset.
- GOTO 0x0A5 at address 0x010: next `pm_addr`=0x0A5; `Instr` is NOP with `instr_valid`=0 for one cycle; then `Instr`=ROM[0x0A5].
- CALL 0x40 at 0x020, then RETLW at 0x040: S0=0x021; then PC=0x021, depth returns to 0; each transfer costs 2 cycles.
- Three nested CALLs from 0x001, 0x101, 0x102: `stack_ovf`=1 after the third; S0=0x103, S1=0x102; first RETLW goes to 0x103, second to 0x102.
- `skip`=1 while executing 0x030: ROM[0x031] is never presented on `Instr`; next valid `Instr`=ROM[0x032].
- `stall` asserted during a GOTO for 3 cycles: PC and `Instr` hold, and the redirect happens on the first unstalled cycle. `rst` asserted mid-stall: PC=1FF at the next cycle.
